cv32e40p_lce_marker_injector: RTL and testbench
===============================================

# cv32e40p_lce_marker_injector

Producer side of the loop/control-flow-error (LCE) basic-block watchdog. It sits on the IF→ID instruction path and counts instructions handed to ID since the last block marker (`32'h0000006f`). Before the downstream LCE detector's budget runs out, it inserts a synthetic marker into the stream. ID consumes the injected marker as a NOP, and the detector reloads on it. As a result, legitimate long straight-line code never raises a false alarm, while a stuck or hijacked stream still does.

## Interface
Parameters:
- `MAX_BB_LEN`, default 32: detector budget. It must equal the detector's setting and be ≥2.
- `INJ_THRESHOLD`, default `MAX_BB_LEN-1`: number of non-marker transfers after which a marker is injected. Legal range is 1..`MAX_BB_LEN-1`.

Ports:
- `clk`, input, 1: core clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable_i`, input, 1: injection enable. When low, the block is a pure pass-through.
- `instr_valid_i`, input, 1: upstream (prefetch) instruction valid.
- `instr_rdata_i`, input, 32: upstream instruction word.
- `instr_ready_o`, output, 1: upstream ready.
- `instr_valid_o`, output, 1: valid toward ID.
- `instr_rdata_o`, output, 32: instruction word toward ID.
- `marker_o`, output, 1: the current `instr_rdata_o` is a marker, either injected or passed through.
- `injecting_o`, output, 1: the current output beat is synthetic, so ID must treat it as a NOP.
- `inj_count_o`, output, 32: injected-marker count. Present only under `CV32E40P_LCE_INJ_STATS_EN`.

## Operation
States:
- PASS:
  - `instr_valid_o = instr_valid_i`.
  - `instr_rdata_o = instr_rdata_i`.
  - `instr_ready_o = instr_ready_i`.
  - `injecting_o = 0`.
- INJECT:
  - `instr_valid_o = 1`.
  - `instr_rdata_o = 32'h0000006f`.
  - `instr_ready_o = 0`.
  - `marker_o = 1`.
  - `injecting_o = 1`.

Transfer means valid_o & ready_i in the same cycle.

Counter `bb_cnt`:
- Width is `$clog2(MAX_BB_LEN+1)`. It never exceeds `INJ_THRESHOLD` and never wraps.
- On a PASS transfer where `instr_rdata_i == 32'h0000006f`: `bb_cnt ← 0`, and `marker_o = 1`.
- On a PASS transfer of any other word: `bb_cnt ← bb_cnt+1`.
- On an INJECT transfer: `bb_cnt ← 0`, and the state returns to PASS.

Transitions:
- PASS→INJECT when a non-marker transfer makes `bb_cnt+1 == INJ_THRESHOLD` and `enable_i = 1`.
- INJECT→PASS only on an INJECT transfer.

`enable_i` behaviour:
- While low in PASS: `bb_cnt` is held at 0 and no injection occurs.
- Deasserted while in INJECT: the marker is still presented until it transfers, because valid must never drop before the handshake. The block then returns to PASS with the count at 0.
- Reasserted: counting restarts from 0.

Simultaneous events:
- An upstream marker on the same transfer that reaches the threshold: the marker wins, `bb_cnt ← 0`, and the state stays in PASS (no double marker).
- `instr_ready_i = 0` in INJECT: hold all outputs stable.

## Timing
- Pass-through is combinational, with zero-cycle latency.
- An injection costs exactly one extra output beat. Upstream stalls for that beat, and the upstream word is not consumed.
- INJECT is entered in the cycle after the threshold transfer. The marker is visible from that cycle on.
- Reset values:
  - state PASS, `bb_cnt` 0.
  - `instr_valid_o` follows `instr_valid_i`.
  - `marker_o`, `injecting_o` 0 unless the input word is a marker.
  - `inj_count_o` 0.
- Reset mid-INJECT: the block returns asynchronously to PASS with the count cleared, and the pending marker is dropped.
- With the detector's decrement tied to ID transfers, the detector counter never falls below `MAX_BB_LEN-INJ_THRESHOLD`.

## Configuration
- `CV32E40P_LCE_INJ_STATS_EN` defined:
  - `inj_count_o` exists.
  - It increments by 1 on each INJECT transfer (not on pass-through markers).
  - It wraps modulo 2^32.
- Not defined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Package `cv32e40p_lce_pkg` holds:
  - `LCE_MARKER = 32'h0000006f`.
  - State enum `lce_inj_state_e` {`LCE_INJ_PASS`, `LCE_INJ_INJECT`}.
  - It is shared with the detector.
- Sub-module `cv32e40p_lce_bb_counter` holds the clear/increment/threshold-hit counter, parameterised by width and threshold.
- The top level holds the FSM and output muxing.

## Test plan
- `INJ_THRESHOLD=3`, continuous valid/ready, enable=1, words `0x00000013`×5 → output sequence `13,13,13,6f(injecting_o=1),13,13`; upstream stalled exactly one cycle.
- Upstream marker `0x6f` as the 2nd word → passes with `marker_o=1`, `injecting_o=0`; count resets, so the next injection occurs after 3 more NOPs.
- In INJECT, hold `instr_ready_i=0` for 4 cycles → marker stable, `instr_ready_o=0` throughout; transfer on the 5th cycle → PASS.
- Deassert `enable_i` during INJECT → marker still completes; then 10 NOPs pass with no injection.
- Assert `rst_n=0` mid-INJECT → outputs revert to pass-through immediately; after release, first injection comes after 3 transfers.
- Stats build: 3 injections plus 2 upstream markers → `inj_count_o = 3`; preload to 2^32−1 via force → wraps to 0.

Source files
------------

// File: rtl/cv32e40p_lce_pkg.sv
// LCE shared definitions: block marker word and injector states.
// Used by the marker injector and by the downstream LCE detector.
package cv32e40p_lce_pkg;

  localparam logic [31:0] LCE_MARKER = 32'h0000006f;

  typedef enum logic {
    LCE_INJ_PASS,
    LCE_INJ_INJECT
  } lce_inj_state_e;

  function automatic logic lce_is_marker(
    input logic [31:0] word
  );
    return word == LCE_MARKER;
  endfunction

endpackage

// File: rtl/cv32e40p_lce_marker_injector_if.sv
// IF->ID instruction stream as seen by the LCE marker injector.
// slave: injector side; master: prefetch/ID side driving it.
interface cv32e40p_lce_marker_injector_if;

  logic        instr_valid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_ready_o;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_ready_i;
  logic        marker_o;
  logic        injecting_o;

  modport slave (
    input  instr_valid_i,
    input  instr_rdata_i,
    input  instr_ready_i,
    output instr_ready_o,
    output instr_valid_o,
    output instr_rdata_o,
    output marker_o,
    output injecting_o
  );

  modport master (
    output instr_valid_i,
    output instr_rdata_i,
    output instr_ready_i,
    input  instr_ready_o,
    input  instr_valid_o,
    input  instr_rdata_o,
    input  marker_o,
    input  injecting_o
  );

endinterface

// File: rtl/cv32e40p_lce_bb_counter.sv
// Basic-block length counter: clear wins over increment,
// saturates at THRESH, hit flags the increment that reaches THRESH.
module cv32e40p_lce_bb_counter #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned THRESH = 31
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [WIDTH-1:0] TH    = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] TH_M1 = WIDTH'(THRESH - 1);

  logic [WIDTH-1:0] cnt_q;

  assign hit = inc & ~clr & (cnt_q == TH_M1);

  // count transfers since the last marker, never past the threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && cnt_q != TH) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cv32e40p_lce_marker_injector.sv
// LCE marker injector on the IF->ID path: inserts a block marker
// before the detector budget expires. Stats: CV32E40P_LCE_INJ_STATS_EN.
module cv32e40p_lce_marker_injector
  import cv32e40p_lce_pkg::*;
#(
  parameter int unsigned MAX_BB_LEN    = 32,
  parameter int unsigned INJ_THRESHOLD = MAX_BB_LEN - 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
`ifdef CV32E40P_LCE_INJ_STATS_EN
  output logic [31:0] inj_count_o,
`endif
  cv32e40p_lce_marker_injector_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BB_LEN + 1);

  lce_inj_state_e state_q;
  lce_inj_state_e state_d;

  logic up_mk;
  logic pass_xfer;
  logic inj_xfer;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_hit;

  assign up_mk = lce_is_marker(bus.instr_rdata_i);

  assign pass_xfer = (state_q == LCE_INJ_PASS)
                   & bus.instr_valid_i
                   & bus.instr_ready_i;

  assign inj_xfer = (state_q == LCE_INJ_INJECT)
                  & bus.instr_ready_i;

  // upstream marker wins over a threshold hit on the same beat
  assign cnt_inc = pass_xfer & ~up_mk & enable_i;
  assign cnt_clr = inj_xfer
                 | (pass_xfer & up_mk)
                 | ~enable_i;

  cv32e40p_lce_bb_counter #(
    .WIDTH  (CNT_W),
    .THRESH (INJ_THRESHOLD)
  ) u_bb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .hit   (cnt_hit)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LCE_INJ_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and output mux
  always_comb begin
    state_d           = state_q;
    bus.instr_valid_o = bus.instr_valid_i;
    bus.instr_rdata_o = bus.instr_rdata_i;
    bus.instr_ready_o = bus.instr_ready_i;
    bus.marker_o      = up_mk;
    bus.injecting_o   = 1'b0;
    unique case (state_q)
      LCE_INJ_PASS: begin
        if (cnt_hit) begin
          state_d = LCE_INJ_INJECT;
        end
      end
      LCE_INJ_INJECT: begin
        bus.instr_valid_o = 1'b1;
        bus.instr_rdata_o = LCE_MARKER;
        bus.instr_ready_o = 1'b0;
        bus.marker_o      = 1'b1;
        bus.injecting_o   = 1'b1;
        if (bus.instr_ready_i) begin
          state_d = LCE_INJ_PASS;
        end
      end
    endcase
  end

`ifdef CV32E40P_LCE_INJ_STATS_EN
  logic [31:0] inj_cnt_q;

  // count synthetic markers accepted by ID, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt_q <= '0;
    end else if (inj_xfer) begin
      inj_cnt_q <= inj_cnt_q + 32'd1;
    end
  end

  assign inj_count_o = inj_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_lce_marker_injector.sv
// Bench for the LCE marker injector, INJ_THRESHOLD=3.
// Vector table plus reset and stats sequences.
module tb_cv32e40p_lce_marker_injector;

  localparam logic [31:0] MK  = 32'h0000006f;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  cv32e40p_lce_marker_injector_if ifc();

`ifdef CV32E40P_LCE_INJ_STATS_EN
  logic [31:0] inj_count;
`endif

  cv32e40p_lce_marker_injector #(
    .MAX_BB_LEN    (32),
    .INJ_THRESHOLD (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
`ifdef CV32E40P_LCE_INJ_STATS_EN
    .inj_count_o (inj_count),
`endif
    .bus         (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic        r;
    logic [31:0] d;
    logic        ev;
    logic        er;
    logic        em;
    logic        ei;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {28'd0, ifc.instr_valid_o, ifc.instr_ready_o,
            ifc.marker_o, ifc.injecting_o, ifc.instr_rdata_o};
  endfunction

  function automatic logic [63:0] want(
    input logic ev, er, em, ei,
    input logic [31:0] ed);
    return {28'd0, ev, er, em, ei, ed};
  endfunction

  function automatic void add(
    input logic en, v, r,
    input logic [31:0] d,
    input logic ev, er, em, ei,
    input logic [31:0] ed);
    vec_t t;
    t.en = en; t.v = v; t.r = r; t.d = d;
    t.ev = ev; t.er = er; t.em = em; t.ei = ei;
    t.ed = ed;
    tbl.push_back(t);
  endfunction

  function automatic void add_p(input logic en, input int n);
    for (int k = 0; k < n; k++)
      add(en, 1, 1, NOP, 1, 1, 0, 0, NOP);
  endfunction

  function automatic void add_i(input logic en, input logic r);
    add(en, 1, r, NOP, 1, 0, 1, 1, MK);
  endfunction

  // drive on falling edge, leave 2ns before sampling
  task automatic drive(input logic en, v, r,
                       input logic [31:0] d);
    @(negedge clk);
    enable = en;
    ifc.instr_valid_i = v;
    ifc.instr_ready_i = r;
    ifc.instr_rdata_i = d;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    enable = 1'b1;
    ifc.instr_valid_i = 1'b1;
    ifc.instr_ready_i = 1'b1;
    ifc.instr_rdata_i = MK;
    #2;
    chk("rst_marker", outs(), want(1, 1, 1, 0, MK));
    ifc.instr_valid_i = 1'b0;
    ifc.instr_rdata_i = NOP;
    #1;
    chk("rst_pass", outs(), want(0, 1, 0, 0, NOP));
`ifdef CV32E40P_LCE_INJ_STATS_EN
    chk("rst_inj_cnt", 64'(inj_count), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    add_p(1, 3);
    add_i(1, 1);
    add_p(1, 2);
    add(1, 1, 1, MK, 1, 1, 1, 0, MK);
    add_p(1, 1);
    add(1, 1, 0, NOP, 1, 0, 0, 0, NOP);
    add(1, 0, 1, NOP, 0, 1, 0, 0, NOP);
    add_p(1, 2);
    for (int k = 0; k < 4; k++) add_i(1, 0);
    add_i(1, 1);
    add_p(1, 3);
    add_i(0, 1);
    add_p(0, 10);
    add_p(1, 3);
    add_i(1, 1);
    add_p(1, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d", i), outs(),
          want(tbl[i].ev, tbl[i].er, tbl[i].em,
               tbl[i].ei, tbl[i].ed));
    end

`ifdef CV32E40P_LCE_INJ_STATS_EN
    chk("inj_cnt_4", 64'(inj_count), 64'd4);
    force dut.inj_cnt_q = 32'hffffffff;
    #1;
    release dut.inj_cnt_q;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      drive(1, 1, 1, NOP);
      seen = ifc.injecting_o;
    end
    chk("wrap_inj_seen", 64'(seen), 64'd1);
    drive(1, 1, 1, NOP);
    chk("inj_cnt_wrap", 64'(inj_count), 64'd0);
`endif

    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      drive(1, 1, 1, NOP);
      seen = ifc.injecting_o;
    end
    chk("pre_rst_inj", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_inj", outs(), want(1, 1, 0, 0, NOP));
    ifc.instr_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, NOP);
      chk($sformatf("post_rst%0d", k), outs(),
          want(1, 1, 0, 0, NOP));
    end
    drive(1, 1, 1, NOP);
    chk("post_rst_inj", outs(), want(1, 0, 1, 1, MK));
    drive(1, 1, 1, NOP);
    chk("post_rst_pass", outs(), want(1, 1, 0, 0, NOP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
